// File: rtl/alu_pkg.sv
// ALUFN opcode constants shared by the command sequencer and its users,
// plus the legality check that decides which codes may be issued to the ALU.
package alu_pkg;

  localparam int ALUFN_W = 6;

  localparam logic [ALUFN_W-1:0] ALUFN_NOP   = 6'b000000;
  localparam logic [ALUFN_W-1:0] ALUFN_CMPEQ = 6'b000011;
  localparam logic [ALUFN_W-1:0] ALUFN_CMPLT = 6'b000101;
  localparam logic [ALUFN_W-1:0] ALUFN_CMPLE = 6'b000111;
  localparam logic [ALUFN_W-1:0] ALUFN_ADD   = 6'b010000;
  localparam logic [ALUFN_W-1:0] ALUFN_SUB   = 6'b010001;
  localparam logic [ALUFN_W-1:0] ALUFN_AND   = 6'b101000;
  localparam logic [ALUFN_W-1:0] ALUFN_OR    = 6'b101110;
  localparam logic [ALUFN_W-1:0] ALUFN_XOR   = 6'b100110;
  localparam logic [ALUFN_W-1:0] ALUFN_XNOR  = 6'b101001;
  localparam logic [ALUFN_W-1:0] ALUFN_A     = 6'b101010;
  localparam logic [ALUFN_W-1:0] ALUFN_SHL   = 6'b110000;
  localparam logic [ALUFN_W-1:0] ALUFN_SHR   = 6'b110001;
  localparam logic [ALUFN_W-1:0] ALUFN_SRA   = 6'b110011;

  function automatic logic is_legal_alufn(input logic [ALUFN_W-1:0] fn);
    logic legal;
    legal = 1'b0;
    case (fn)
      ALUFN_CMPEQ, ALUFN_CMPLT, ALUFN_CMPLE,
      ALUFN_ADD,   ALUFN_SUB,
      ALUFN_AND,   ALUFN_OR,    ALUFN_XOR,   ALUFN_XNOR, ALUFN_A,
      ALUFN_SHL,   ALUFN_SHR,   ALUFN_SRA:   legal = 1'b1;
      default:                               legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through head and extra-bit pointers.
// A push into a full FIFO is only taken when the same cycle also pops.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);

  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_rd) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage has no reset; validity is carried entirely by the pointers.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Feeds an external registered 32-bit ALU from a command FIFO, tracks its one-cycle
// latency with a two-stage pipe, and returns tagged results in order via a result FIFO.
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int CMD_DEPTH = 4,
  parameter int RES_DEPTH = 4,
  parameter int TAG_W     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [5:0]        cmd_fn,
  input  logic [31:0]       cmd_a,
  input  logic [31:0]       cmd_b,
  input  logic [TAG_W-1:0]  cmd_tag,
  output logic [5:0]        alu_fn,
  output logic [31:0]       alu_a,
  output logic [31:0]       alu_b,
  input  logic [31:0]       alu_y,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [31:0]       res_y,
  output logic [TAG_W-1:0]  res_tag,
  output logic              res_err
);

  localparam int CMD_W    = TAG_W + 70;
  localparam int RES_W    = TAG_W + 33;
  localparam int CREDIT_W = $clog2(RES_DEPTH) + 1;
  localparam logic [CREDIT_W-1:0] CREDIT_MAX = CREDIT_W'(RES_DEPTH);

  logic              cmd_full;
  logic              cmd_empty;
  logic              cmd_push;
  logic [CMD_W-1:0]  cmd_wdata;
  logic [CMD_W-1:0]  cmd_head;

  logic [5:0]        head_fn;
  logic [31:0]       head_a;
  logic [31:0]       head_b;
  logic [TAG_W-1:0]  head_tag;
  logic              head_legal;
  logic              issue;

  logic              s1_valid_reg;
  logic              s1_err_reg;
  logic [TAG_W-1:0]  s1_tag_reg;
  logic              s2_valid_reg;
  logic              s2_err_reg;
  logic [TAG_W-1:0]  s2_tag_reg;

  logic [CREDIT_W-1:0] credit_reg;

  logic              res_full;
  logic              res_empty;
  logic              res_push;
  logic              res_pop;
  logic [RES_W-1:0]  res_wdata;
  logic [RES_W-1:0]  res_head;

  // Command path
  assign cmd_ready = !cmd_full;
  assign cmd_push  = cmd_valid && !cmd_full;
  assign cmd_wdata = {cmd_tag, cmd_fn, cmd_a, cmd_b};

  sync_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (CMD_DEPTH)
  ) u_cmd_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (cmd_push),
    .wr_data (cmd_wdata),
    .rd_en   (issue),
    .rd_data (cmd_head),
    .full    (cmd_full),
    .empty   (cmd_empty)
  );

  assign head_tag   = cmd_head[CMD_W-1 -: TAG_W];
  assign head_fn    = cmd_head[69:64];
  assign head_a     = cmd_head[63:32];
  assign head_b     = cmd_head[31:0];
  assign head_legal = is_legal_alufn(head_fn);

  // Credit covers both in-flight ops and held results, so the result FIFO never overflows.
  assign issue = !cmd_empty && (credit_reg < CREDIT_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_fn <= ALUFN_NOP;
      alu_a  <= '0;
      alu_b  <= '0;
    end else if (issue) begin
      alu_fn <= head_legal ? head_fn : ALUFN_NOP;
      alu_a  <= head_a;
      alu_b  <= head_b;
    end else begin
      alu_fn <= ALUFN_NOP;
    end
  end

  // Stage 1: ALU samples this op at the next edge. Stage 2: alu_y now holds its result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
      s1_err_reg   <= 1'b0;
      s1_tag_reg   <= '0;
      s2_valid_reg <= 1'b0;
      s2_err_reg   <= 1'b0;
      s2_tag_reg   <= '0;
    end else begin
      s1_valid_reg <= issue;
      s1_err_reg   <= issue && !head_legal;
      s1_tag_reg   <= head_tag;
      s2_valid_reg <= s1_valid_reg;
      s2_err_reg   <= s1_err_reg;
      s2_tag_reg   <= s1_tag_reg;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credit_reg <= '0;
    end else begin
      case ({issue, res_pop})
        2'b10:   credit_reg <= credit_reg + CREDIT_W'(1);
        2'b01:   credit_reg <= credit_reg - CREDIT_W'(1);
        default: credit_reg <= credit_reg;
      endcase
    end
  end

  // Result path
  assign res_push  = s2_valid_reg && !res_full;
  assign res_wdata = {s2_tag_reg, s2_err_reg, (s2_err_reg ? 32'd0 : alu_y)};
  assign res_pop   = res_valid && res_ready;

  sync_fifo #(
    .WIDTH (RES_W),
    .DEPTH (RES_DEPTH)
  ) u_res_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (res_push),
    .wr_data (res_wdata),
    .rd_en   (res_pop),
    .rd_data (res_head),
    .full    (res_full),
    .empty   (res_empty)
  );

  assign res_valid = !res_empty;
  assign res_tag   = res_head[RES_W-1 -: TAG_W];
  assign res_err   = res_head[32];
  assign res_y     = res_head[31:0];

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer with a behavioural registered ALU attached:
// table-driven single ops plus streaming, back-pressure, illegal-code and reset sequences.
module tb_alu_cmd_sequencer;
  import alu_pkg::*;

  localparam int TAG_W     = 4;
  localparam int CMD_DEPTH = 4;
  localparam int RES_DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [5:0]       cmd_fn = '0;
  logic [31:0]      cmd_a = '0;
  logic [31:0]      cmd_b = '0;
  logic [TAG_W-1:0] cmd_tag = '0;
  logic [5:0]       alu_fn;
  logic [31:0]      alu_a;
  logic [31:0]      alu_b;
  logic [31:0]      alu_y = '0;
  logic             res_valid;
  logic             res_ready = 1'b1;
  logic [31:0]      res_y;
  logic [TAG_W-1:0] res_tag;
  logic             res_err;

  always #5 clk = ~clk;

  alu_cmd_sequencer #(
    .CMD_DEPTH (CMD_DEPTH),
    .RES_DEPTH (RES_DEPTH),
    .TAG_W     (TAG_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_fn    (cmd_fn),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .cmd_tag   (cmd_tag),
    .alu_fn    (alu_fn),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_y     (alu_y),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_y     (res_y),
    .res_tag   (res_tag),
    .res_err   (res_err)
  );

  // Registered ALU with no enable or reset: NOP holds Y.
  function automatic logic [31:0] alu_model(input logic [5:0] fn, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [31:0] y;
    y = 32'd0;
    case (fn)
      ALUFN_CMPEQ: y = {31'd0, (a == b)};
      ALUFN_CMPLT: y = {31'd0, ($signed(a) < $signed(b))};
      ALUFN_CMPLE: y = {31'd0, ($signed(a) <= $signed(b))};
      ALUFN_ADD:   y = a + b;
      ALUFN_SUB:   y = a - b;
      ALUFN_AND:   y = a & b;
      ALUFN_OR:    y = a | b;
      ALUFN_XOR:   y = a ^ b;
      ALUFN_XNOR:  y = ~(a ^ b);
      ALUFN_A:     y = a;
      ALUFN_SHL:   y = a << b[4:0];
      ALUFN_SHR:   y = a >> b[4:0];
      ALUFN_SRA:   y = $unsigned($signed(a) >>> b[4:0]);
      default:     y = 32'd0;
    endcase
    return y;
  endfunction

  always @(posedge clk) begin
    if (alu_fn != ALUFN_NOP) alu_y <= alu_model(alu_fn, alu_a, alu_b);
  end

  typedef struct {
    string            name;
    logic [5:0]       fn;
    logic [31:0]      a;
    logic [31:0]      b;
    logic [TAG_W-1:0] tag;
    logic [31:0]      y;
    logic             err;
  } vec_t;

  localparam int NVEC = 15;
  vec_t vecs [NVEC];

  int n_pass  = 0;
  int n_total = 0;
  logic saw_bad_fn = 1'b0;

  logic [31:0]      got_y   [$];
  logic [TAG_W-1:0] got_tag [$];
  logic             got_err [$];
  int               got_cyc [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (alu_fn == 6'b111111) saw_bad_fn = 1'b1;
  endtask

  task automatic drive(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b,
                       input logic [TAG_W-1:0] tag);
    cmd_fn    = fn;
    cmd_a     = a;
    cmd_b     = b;
    cmd_tag   = tag;
    cmd_valid = 1'b1;
  endtask

  task automatic collect(input int n, input int budget);
    got_y.delete();
    got_tag.delete();
    got_err.delete();
    got_cyc.delete();
    for (int c = 0; c < budget; c++) begin
      if (res_valid && res_ready) begin
        got_y.push_back(res_y);
        got_tag.push_back(res_tag);
        got_err.push_back(res_err);
        got_cyc.push_back(c);
      end
      step();
      if (got_y.size() >= n) break;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int acc_n;
    int ok_cnt;
    logic ready_now;
    logic seen;

    vecs[0]  = '{"add",    ALUFN_ADD,   32'd5,        32'd7,      4'd3,  32'd12,        1'b0};
    vecs[1]  = '{"cmplt",  ALUFN_CMPLT, -32'sd3,      32'd2,      4'd1,  32'd1,         1'b0};
    vecs[2]  = '{"sra",    ALUFN_SRA,   32'h80000000, 32'd4,      4'd2,  32'hF8000000,  1'b0};
    vecs[3]  = '{"sub",    ALUFN_SUB,   32'd0,        32'd1,      4'd4,  32'hFFFFFFFF,  1'b0};
    vecs[4]  = '{"xnor",   ALUFN_XNOR,  32'd0,        32'd0,      4'd5,  32'hFFFFFFFF,  1'b0};
    vecs[5]  = '{"cmpeq",  ALUFN_CMPEQ, 32'd9,        32'd9,      4'd6,  32'd1,         1'b0};
    vecs[6]  = '{"cmple",  ALUFN_CMPLE, 32'd3,        32'd2,      4'd7,  32'd0,         1'b0};
    vecs[7]  = '{"cmple_eq", ALUFN_CMPLE, 32'd4,      32'd4,      4'd8,  32'd1,         1'b0};
    vecs[8]  = '{"and",    ALUFN_AND,   32'h0000F0F0, 32'h0000FF00, 4'd9,  32'h0000F000, 1'b0};
    vecs[9]  = '{"or",     ALUFN_OR,    32'h0000F0F0, 32'h0000FF00, 4'd10, 32'h0000FFF0, 1'b0};
    vecs[10] = '{"xor",    ALUFN_XOR,   32'h0000F0F0, 32'h0000FF00, 4'd11, 32'h00000FF0, 1'b0};
    vecs[11] = '{"pass_a", ALUFN_A,     32'h00001234, 32'd0,      4'd12, 32'h00001234,  1'b0};
    vecs[12] = '{"shl",    ALUFN_SHL,   32'd1,        32'd31,     4'd13, 32'h80000000,  1'b0};
    vecs[13] = '{"shr",    ALUFN_SHR,   32'h80000000, 32'd31,     4'd14, 32'd1,         1'b0};
    vecs[14] = '{"illegal", 6'b111111,  32'd5,        32'd7,      4'd15, 32'd0,         1'b1};

    // Reset state
    step();
    step();
    chk("rst_alu_fn",    32'(alu_fn),    32'd0);
    chk("rst_alu_a",     alu_a,          32'd0);
    chk("rst_alu_b",     alu_b,          32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    rst = 1'b0;
    step();

    // Single ops from the table, each checked for value, tag, error and latency
    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].fn, vecs[i].a, vecs[i].b, vecs[i].tag);
      step();
      cmd_valid = 1'b0;
      lat = 0;
      while (!res_valid && lat < 20) begin
        step();
        lat++;
      end
      chk({vecs[i].name, "_lat"}, 32'(lat), 32'd3);
      chk({vecs[i].name, "_y"},   res_y,           vecs[i].y);
      chk({vecs[i].name, "_tag"}, 32'(res_tag),    32'(vecs[i].tag));
      chk({vecs[i].name, "_err"}, 32'(res_err),    32'(vecs[i].err));
      $display("vec %s: y=0x%08h tag=%0d err=%0d lat=%0d", vecs[i].name, res_y, res_tag, res_err, lat);
      step();
    end
    saw_bad_fn = 1'b0;

    // Back-to-back stream: results must come out on consecutive cycles, in order
    for (int i = 1; i <= 4; i++) begin
      drive(vecs[i].fn, vecs[i].a, vecs[i].b, vecs[i].tag);
      step();
    end
    cmd_valid = 1'b0;
    collect(4, 20);
    chk("stream_count", 32'(got_y.size()), 32'd4);
    for (int i = 0; i < got_y.size(); i++) begin
      chk("stream_y",   got_y[i],           vecs[i+1].y);
      chk("stream_tag", 32'(got_tag[i]),    32'(vecs[i+1].tag));
      $display("stream %0d: y=0x%08h tag=%0d cyc=%0d", i, got_y[i], got_tag[i], got_cyc[i]);
    end
    if (got_cyc.size() == 4) chk("stream_gapless", 32'(got_cyc[3] - got_cyc[0]), 32'd3);

    // Illegal code between two ADDs
    drive(ALUFN_ADD, 32'd10, 32'd20, 4'd5);
    step();
    drive(6'b111111, 32'd1, 32'd2, 4'd6);
    step();
    drive(ALUFN_ADD, 32'hFFFFFFFF, 32'd1, 4'd7);
    step();
    cmd_valid = 1'b0;
    collect(3, 20);
    chk("illeg_count", 32'(got_y.size()), 32'd3);
    if (got_y.size() == 3) begin
      chk("illeg_y0",   got_y[0],         32'd30);
      chk("illeg_err0", 32'(got_err[0]),  32'd0);
      chk("illeg_y1",   got_y[1],         32'd0);
      chk("illeg_err1", 32'(got_err[1]),  32'd1);
      chk("illeg_tag1", 32'(got_tag[1]),  32'd6);
      chk("illeg_y2",   got_y[2],         32'd0);
      chk("illeg_err2", 32'(got_err[2]),  32'd0);
      chk("illeg_tag2", 32'(got_tag[2]),  32'd7);
    end
    chk("illeg_alu_fn_nop", 32'(saw_bad_fn), 32'd0);
    $display("illegal: saw_bad_fn=%0d", saw_bad_fn);

    // Back-pressure: fill both FIFOs with res_ready low
    res_ready = 1'b0;
    acc_n = 0;
    for (int i = 0; i < 10; i++) begin
      drive(ALUFN_ADD, 32'(acc_n), 32'd100, acc_n[TAG_W-1:0]);
      ready_now = cmd_ready;
      step();
      if (ready_now) acc_n++;
    end
    cmd_valid = 1'b0;
    step();
    step();
    step();
    chk("bp_accepted",  32'(acc_n),     32'(RES_DEPTH + CMD_DEPTH));
    chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("bp_res_valid", 32'(res_valid), 32'd1);
    chk("bp_head_y",    res_y,          32'd100);
    $display("backpressure: accepted=%0d cmd_ready=%0d", acc_n, cmd_ready);

    // Release while still pushing: credit at the limit with a same-cycle pop
    res_ready = 1'b1;
    got_y.delete();
    got_tag.delete();
    got_cyc.delete();
    for (int c = 0; c < 60; c++) begin
      if (acc_n < 12) drive(ALUFN_ADD, 32'(acc_n), 32'd100, acc_n[TAG_W-1:0]);
      else cmd_valid = 1'b0;
      ready_now = cmd_ready && cmd_valid;
      if (res_valid) begin
        got_y.push_back(res_y);
        got_tag.push_back(res_tag);
        got_cyc.push_back(c);
      end
      step();
      if (ready_now) acc_n++;
      if (got_y.size() >= 12) break;
    end
    cmd_valid = 1'b0;
    chk("rel_count", 32'(got_y.size()), 32'd12);
    ok_cnt = 0;
    for (int i = 0; i < got_y.size(); i++) begin
      if (got_y[i] === 32'(i + 100) && got_tag[i] === 4'(i)) ok_cnt++;
    end
    chk("rel_in_order", 32'(ok_cnt), 32'd12);
    if (got_cyc.size() == 12) chk("rel_gapless", 32'(got_cyc[11] - got_cyc[0]), 32'd11);
    $display("release: results=%0d in_order=%0d", got_y.size(), ok_cnt);
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (res_valid) seen = 1'b1;
      step();
    end
    chk("rel_no_dup", 32'(seen), 32'd0);

    // Reset with ops in flight
    drive(ALUFN_ADD, 32'd1, 32'd1, 4'd1);
    step();
    drive(ALUFN_ADD, 32'd2, 32'd2, 4'd2);
    step();
    drive(ALUFN_ADD, 32'd3, 32'd3, 4'd3);
    step();
    cmd_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_alu_fn",    32'(alu_fn),    32'd0);
    chk("mid_rst_alu_a",     alu_a,          32'd0);
    chk("mid_rst_res_valid", 32'(res_valid), 32'd0);
    chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    step();
    step();
    rst = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (res_valid) seen = 1'b1;
      step();
    end
    chk("mid_rst_no_stale", 32'(seen), 32'd0);
    $display("mid reset: stale_result_seen=%0d", seen);

    // First op after reset
    drive(ALUFN_ADD, 32'd5, 32'd7, 4'd3);
    step();
    cmd_valid = 1'b0;
    collect(1, 20);
    chk("post_rst_count", 32'(got_y.size()), 32'd1);
    if (got_y.size() == 1) begin
      chk("post_rst_y",   got_y[0],        32'd12);
      chk("post_rst_tag", 32'(got_tag[0]), 32'd3);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
